// File: rtl/fetch_decode_unit.sv
// Y86-64 front end: byte-addressed instruction memory, fetch/align/decode and a
// 15-entry register file with combinational reads and dual writeback ports.
module fetch_decode_unit #(
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] PC_i,
  input  logic        imem_we_i,
  input  logic [63:0] imem_waddr_i,
  input  logic [7:0]  imem_wdata_i,
  input  logic [3:0]  dstE_i,
  input  logic [63:0] valE_i,
  input  logic [3:0]  dstM_i,
  input  logic [63:0] valM_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifunc_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o,
  output logic        instr_valid_o,
  output logic        imem_error_o,
  output logic [63:0] valA_o,
  output logic [63:0] valB_o
);

  localparam int unsigned AW    = $clog2(IMEM_BYTES);
  localparam int unsigned NREGS = 15;
  localparam logic [3:0]  RNONE = 4'hF;
  localparam logic [3:0]  RSP   = 4'h4;

  logic [7:0]      imem [IMEM_BYTES];
  logic [63:0]     regs [NREGS];
  logic [9:0][7:0] fb;
  logic [3:0]      raw_icode;
  logic [3:0]      raw_ifunc;
  logic [3:0]      len;
  logic [3:0]      src_a;
  logic [3:0]      src_b;

  // Program load port; addresses past the end of memory are dropped.
  always_ff @(posedge clk_i) begin
    if (imem_we_i && (imem_waddr_i < 64'(IMEM_BYTES))) begin
      imem[imem_waddr_i[AW-1:0]] <= imem_wdata_i;
    end
  end

  // Ten-byte fetch window; bytes beyond memory read as zero and are flagged below.
  for (genvar k = 0; k < 10; k++) begin : g_fetch
    logic [64:0] addr;
    assign addr  = {1'b0, PC_i} + 65'(k);
    assign fb[k] = (addr < 65'(IMEM_BYTES)) ? imem[addr[AW-1:0]] : 8'h00;
  end

  assign raw_icode = fb[0][7:4];
  assign raw_ifunc = fb[0][3:0];

  always_comb begin
    len = 4'd1;
    case (raw_icode)
      4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
      4'h7, 4'h8:             len = 4'd9;
      4'h3, 4'h4, 4'h5:       len = 4'd10;
      default:                len = 4'd1;
    endcase
  end

  // 65-bit end address so a PC near 2^64 cannot wrap into range.
  assign imem_error_o = ({1'b0, PC_i} + 65'(len)) > 65'(IMEM_BYTES);

  always_comb begin
    icode_o       = 4'h1;
    ifunc_o       = 4'h0;
    rA_o          = RNONE;
    rB_o          = RNONE;
    valC_o        = 64'd0;
    instr_valid_o = 1'b1;
    valP_o        = PC_i + 64'd1;
    if (!imem_error_o) begin
      icode_o = raw_icode;
      ifunc_o = raw_ifunc;
      valP_o  = PC_i + 64'(len);
      case (raw_icode)
        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: begin
          rA_o = fb[1][7:4];
          rB_o = fb[1][3:0];
        end
        default: ;
      endcase
      case (raw_icode)
        4'h3, 4'h4, 4'h5: valC_o = {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]};
        4'h7, 4'h8:       valC_o = {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]};
        default:          valC_o = 64'd0;
      endcase
      case (raw_icode)
        4'h2, 4'h7:       instr_valid_o = (raw_ifunc <= 4'd6);
        4'h6:             instr_valid_o = (raw_ifunc <= 4'd3);
        4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                          instr_valid_o = (raw_ifunc == 4'd0);
        default:          instr_valid_o = 1'b0;
      endcase
    end
  end

  // Operand selection; decoded from the post-error icode so a faulted fetch reads nothing.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    case (icode_o)
      4'h2, 4'h4, 4'h6, 4'hA: src_a = rA_o;
      4'h9, 4'hB:             src_a = RSP;
      default:                src_a = RNONE;
    endcase
    case (icode_o)
      4'h4, 4'h5, 4'h6:       src_b = rB_o;
      4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP;
      default:                src_b = RNONE;
    endcase
  end

  assign valA_o = (src_a == RNONE) ? 64'd0 : regs[src_a];
  assign valB_o = (src_b == RNONE) ? 64'd0 : regs[src_b];

  // Register file: M port is written last so it wins a same-register collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= 64'(i);
      end
    end else begin
      if (dstE_i != RNONE) regs[dstE_i] <= valE_i;
      if (dstM_i != RNONE) regs[dstM_i] <= valM_i;
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: behavioural Y86-64 fetch/decode model with a per-cycle
// compare process, directed literal checks and randomized program/writeback traffic.
module tb_fetch_decode_unit;

  localparam int unsigned IMEM_BYTES = 1024;
  localparam logic [3:0]  RNONE      = 4'hF;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [7:0]  imem_wdata;
  logic [3:0]  dst_e;
  logic [63:0] val_e;
  logic [3:0]  dst_m;
  logic [63:0] val_m;
  logic [3:0]  icode, ifunc, ra, rb;
  logic [63:0] valc, valp, vala, valb;
  logic        instr_valid, imem_error;

  always #5 clk = ~clk;

  fetch_decode_unit #(.IMEM_BYTES(IMEM_BYTES)) dut (
    .clk_i(clk), .rst_i(rst), .PC_i(pc),
    .imem_we_i(imem_we), .imem_waddr_i(imem_waddr), .imem_wdata_i(imem_wdata),
    .dstE_i(dst_e), .valE_i(val_e), .dstM_i(dst_m), .valM_i(val_m),
    .icode_o(icode), .ifunc_o(ifunc), .rA_o(ra), .rB_o(rb),
    .valC_o(valc), .valP_o(valp), .instr_valid_o(instr_valid), .imem_error_o(imem_error),
    .valA_o(vala), .valB_o(valb)
  );

  typedef struct {
    logic [3:0]  icode, ifunc, ra, rb;
    logic [63:0] valc, valp, vala, valb;
    logic        valid, err;
  } exp_t;

  logic [7:0]  mmem [IMEM_BYTES];
  logic [63:0] mregs [15];
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;

  // Architectural state of the model.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) mregs[i] = 64'(i);
    end else begin
      if (dst_e != RNONE) mregs[dst_e] = val_e;
      if (dst_m != RNONE) mregs[dst_m] = val_m;
    end
  end

  always @(posedge clk) begin
    if (imem_we && imem_waddr < 64'(IMEM_BYTES)) mmem[imem_waddr[9:0]] = imem_wdata;
  end

  function automatic logic [7:0] mbyte(input logic [64:0] a);
    return (a < 65'(IMEM_BYTES)) ? mmem[a[9:0]] : 8'h00;
  endfunction

  function automatic logic [63:0] rdreg(input logic [3:0] r);
    return (r == RNONE) ? 64'd0 : mregs[r];
  endfunction

  function automatic exp_t model(input logic [63:0] p);
    exp_t        e;
    logic [7:0]  b0, b1;
    int          len, off;
    logic [3:0]  sa, sb;
    logic [64:0] base;
    base = {1'b0, p};
    b0   = mbyte(base);
    b1   = mbyte(base + 65'd1);
    if (b0[7:4] inside {4'h2, 4'h6, 4'hA, 4'hB}) len = 2;
    else if (b0[7:4] inside {4'h7, 4'h8})        len = 9;
    else if (b0[7:4] inside {4'h3, 4'h4, 4'h5})  len = 10;
    else                                         len = 1;
    e.err   = (base + 65'(len)) > 65'(IMEM_BYTES);
    e.icode = 4'h1; e.ifunc = 4'h0; e.ra = RNONE; e.rb = RNONE;
    e.valc  = 64'd0; e.valid = 1'b1; e.valp = p + 64'd1;
    if (!e.err) begin
      e.icode = b0[7:4];
      e.ifunc = b0[3:0];
      e.valp  = p + 64'(len);
      if (e.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
        e.ra = b1[7:4];
        e.rb = b1[3:0];
      end
      off = (e.icode inside {4'h3, 4'h4, 4'h5}) ? 2 : (e.icode inside {4'h7, 4'h8}) ? 1 : 0;
      if (off != 0)
        for (int k = 0; k < 8; k++) e.valc[8*k +: 8] = mbyte(base + 65'(off + k));
      if (e.icode > 4'hB)                      e.valid = 1'b0;
      else if (e.icode == 4'h6)                e.valid = (e.ifunc <= 4'd3);
      else if (e.icode inside {4'h2, 4'h7})    e.valid = (e.ifunc <= 4'd6);
      else                                     e.valid = (e.ifunc == 4'd0);
    end
    sa = (e.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? e.ra :
         (e.icode inside {4'h9, 4'hB}) ? 4'h4 : RNONE;
    sb = (e.icode inside {4'h4, 4'h5, 4'h6}) ? e.rb :
         (e.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : RNONE;
    e.vala = rdreg(sa);
    e.valb = rdreg(sb);
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h pc=%h t=%0t", nm, act, exp, pc, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      e = model(pc);
      cmp("icode", 64'(icode), 64'(e.icode));
      cmp("ifunc", 64'(ifunc), 64'(e.ifunc));
      cmp("rA", 64'(ra), 64'(e.ra));
      cmp("rB", 64'(rb), 64'(e.rb));
      cmp("valC", valc, e.valc);
      cmp("valP", valp, e.valp);
      cmp("valid", 64'(instr_valid), 64'(e.valid));
      cmp("imem_error", 64'(imem_error), 64'(e.err));
      cmp("valA", vala, e.vala);
      cmp("valB", valb, e.valb);
    end
  end

  task automatic wr(input logic [63:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    @(posedge clk); #1;
    imem_we = 1'b0;
  endtask

  task automatic at_pc(input logic [63:0] p);
    @(posedge clk); #1;
    pc = p;
    @(negedge clk); #1;
  endtask

  initial begin
    logic [7:0] prog0 [10];
    prog0 = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b1; pc = 64'd0; imem_we = 1'b0; imem_waddr = 64'd0; imem_wdata = 8'd0;
    dst_e = RNONE; val_e = 64'd0; dst_m = RNONE; val_m = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    for (int a = 0; a < IMEM_BYTES; a++) wr(64'(a), 8'($urandom));
    for (int k = 0; k < 10; k++) wr(64'(k), prog0[k]);
    wr(64'd10, 8'h60); wr(64'd11, 8'h23);
    wr(64'd20, 8'hA0); wr(64'd21, 8'h2F); wr(64'd22, 8'h90);
    wr(64'd30, 8'hC0); wr(64'd31, 8'h61); wr(64'd32, 8'h64);
    wr(64'(IMEM_BYTES - 1), 8'h30);
    chk_en = 1'b1;

    at_pc(64'd0);
    cmp("lit_irmovq_icode", 64'(icode), 64'h3);
    cmp("lit_irmovq_ifunc", 64'(ifunc), 64'h0);
    cmp("lit_irmovq_rA", 64'(ra), 64'hF);
    cmp("lit_irmovq_rB", 64'(rb), 64'h2);
    cmp("lit_irmovq_valC", valc, 64'hA);
    cmp("lit_irmovq_valP", valp, 64'd10);
    cmp("lit_irmovq_valA", vala, 64'd0);
    cmp("lit_irmovq_valB", valb, 64'd0);
    cmp("lit_irmovq_valid", 64'(instr_valid), 64'd1);
    cmp("lit_irmovq_err", 64'(imem_error), 64'd0);

    at_pc(64'd10);
    cmp("lit_addq_icode", 64'(icode), 64'h6);
    cmp("lit_addq_rA", 64'(ra), 64'h2);
    cmp("lit_addq_rB", 64'(rb), 64'h3);
    cmp("lit_addq_valP", valp, 64'd12);
    cmp("lit_addq_valA", vala, 64'd2);
    cmp("lit_addq_valB", valb, 64'd3);

    at_pc(64'd20);
    cmp("lit_pushq_valA", vala, 64'd2);
    cmp("lit_pushq_valB", valb, 64'd4);
    cmp("lit_pushq_valP", valp, 64'd22);
    at_pc(64'd22);
    cmp("lit_ret_rA", 64'(ra), 64'hF);
    cmp("lit_ret_rB", 64'(rb), 64'hF);
    cmp("lit_ret_valA", vala, 64'd4);
    cmp("lit_ret_valB", valb, 64'd4);
    cmp("lit_ret_valP", valp, 64'd23);

    at_pc(64'd30); cmp("lit_C0_valid", 64'(instr_valid), 64'd0);
    at_pc(64'd31); cmp("lit_61_valid", 64'(instr_valid), 64'd1);
    at_pc(64'd32); cmp("lit_64_valid", 64'(instr_valid), 64'd0);

    at_pc(64'(IMEM_BYTES - 1));
    cmp("lit_end_err", 64'(imem_error), 64'd1);
    cmp("lit_end_icode", 64'(icode), 64'h1);
    cmp("lit_end_valP", valp, 64'(IMEM_BYTES));
    at_pc(64'hFFFF_FFFF_FFFF_FFFF);
    cmp("lit_wrap_err", 64'(imem_error), 64'd1);
    cmp("lit_wrap_icode", 64'(icode), 64'h1);
    cmp("lit_wrap_valP", valp, 64'd0);

    // Same-register collision on one edge, then an asynchronous reset between edges.
    @(posedge clk); #1;
    pc = 64'd10; dst_e = 4'd3; val_e = 64'h55; dst_m = 4'd3; val_m = 64'h77;
    @(posedge clk); #1;
    dst_e = RNONE; dst_m = RNONE;
    @(negedge clk); #1;
    cmp("lit_collide_valB", valb, 64'h77);
    rst = 1'b1; #1;
    cmp("lit_async_rst_valB", valb, 64'd3);
    #1 rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      int sel;
      @(posedge clk); #1;
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       pc = 64'($urandom_range(0, IMEM_BYTES + 6));
      else if (sel < 9)  pc = 64'($urandom_range(IMEM_BYTES - 12, IMEM_BYTES + 1));
      else               pc = {$urandom, $urandom};
      dst_e = 4'($urandom); val_e = {$urandom, $urandom};
      dst_m = ($urandom_range(0, 3) == 0) ? dst_e : 4'($urandom);
      val_m = {$urandom, $urandom};
      imem_we    = ($urandom_range(0, 3) == 0);
      imem_waddr = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(IMEM_BYTES, IMEM_BYTES + 64))
                                               : 64'($urandom_range(0, IMEM_BYTES - 1));
      imem_wdata = 8'($urandom);
    end
    @(posedge clk); #1;
    imem_we = 1'b0; dst_e = RNONE; dst_m = RNONE;
    @(negedge clk); #1;
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
